// File: rtl/hyper_arb.sv
// hyper_arb: two-port round-robin arbiter in front of one hyper_xfce HyperRAM
// controller. Serialises single-dword read/write requests, issues one
// rd_req/wr_req pulse per transaction, follows busy/rd_rdy to completion and
// aborts a stalled phase after TMO cycles.
//
// Requester handshake: pN_req acts as "valid" and must stay high, with pN_we,
// pN_addr and pN_wdata stable, until pN_gnt pulses. pN_gnt is the one-cycle
// "ready" that accepts the request; the port may drop or re-arm its request
// after it. Every grant is answered by exactly one pN_done pulse, accompanied
// by pN_rvalid for a successful read or pN_err for a timeout.
module hyper_arb #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 1023
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          p0_req,
  input  logic          p1_req,
  input  logic          p0_we,
  input  logic          p1_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic [DW-1:0] p1_wdata,
  output logic          p0_gnt,
  output logic          p1_gnt,
  output logic          p0_rvalid,
  output logic          p1_rvalid,
  output logic          p0_done,
  output logic          p1_done,
  output logic          p0_err,
  output logic          p1_err,
  output logic [DW-1:0] rdata,
  output logic          ctl_rd_req,
  output logic          ctl_wr_req,
  output logic [AW-1:0] ctl_addr,
  output logic [DW-1:0] ctl_wr_d,
  input  logic [DW-1:0] ctl_rd_d,
  input  logic          ctl_rd_rdy,
  input  logic          ctl_busy,
  output logic [2:0]    dbg_state
);

  // Counter only has to hold 0..TMO-1; the phase ends on the edge it would hit TMO.
  localparam int CW = (TMO < 2) ? 1 : $clog2(TMO);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q;   // 0 = port 0 owns the transaction, 1 = port 1
  logic          we_q;
  logic          last_q;    // port served most recently
  logic          got_q;     // read data already captured in this transaction
  logic [CW-1:0] cnt_q;

  logic          start, pick, finish, timeout, cnt_clr, cap, tmo_hit;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign tmo_hit   = (cnt_q == CW'(TMO - 1));
  assign sel_we    = pick ? p1_we    : p0_we;
  assign sel_addr  = pick ? p1_addr  : p0_addr;
  assign sel_wdata = pick ? p1_wdata : p0_wdata;
  assign dbg_state = state_q;

  // Next-state logic and single-cycle event strobes for the datapath.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    pick    = 1'b0;
    finish  = 1'b0;
    timeout = 1'b0;
    cnt_clr = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!ctl_busy && (p0_req || p1_req)) begin
          start   = 1'b1;
          // On a tie the port not served last wins; otherwise the lone requester.
          pick    = (p0_req && p1_req) ? ~last_q : p1_req;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_BUSY;
        cnt_clr = 1'b1;
      end
      S_WAIT_BUSY: begin
        if (ctl_busy) begin
          state_d = S_WAIT_DONE;
          cnt_clr = 1'b1;
        end else if (tmo_hit) begin
          state_d = S_RESP;
          timeout = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        // rd_rdy together with busy already low is a complete read.
        if (!ctl_busy && (we_q || got_q || ctl_rd_rdy)) begin
          state_d = S_RESP;
          finish  = 1'b1;
        end else if (tmo_hit) begin
          state_d = S_RESP;
          timeout = 1'b1;
        end
        cap = !we_q && ctl_rd_rdy && !timeout;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Registered outputs, transaction context, timeout counter and read capture.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      last_q     <= 1'b1;
      got_q      <= 1'b0;
      cnt_q      <= '0;
      p0_gnt     <= 1'b0;
      p1_gnt     <= 1'b0;
      p0_rvalid  <= 1'b0;
      p1_rvalid  <= 1'b0;
      p0_done    <= 1'b0;
      p1_done    <= 1'b0;
      p0_err     <= 1'b0;
      p1_err     <= 1'b0;
      rdata      <= '0;
      ctl_rd_req <= 1'b0;
      ctl_wr_req <= 1'b0;
      ctl_addr   <= '0;
      ctl_wr_d   <= '0;
    end else begin
      p0_gnt     <= start && !pick;
      p1_gnt     <= start && pick;
      ctl_wr_req <= start && sel_we;
      ctl_rd_req <= start && !sel_we;
      p0_done    <= (finish || timeout) && !owner_q;
      p1_done    <= (finish || timeout) && owner_q;
      p0_err     <= timeout && !owner_q;
      p1_err     <= timeout && owner_q;
      p0_rvalid  <= finish && !we_q && !owner_q;
      p1_rvalid  <= finish && !we_q && owner_q;
      if (start) begin
        owner_q  <= pick;
        we_q     <= sel_we;
        last_q   <= pick;
        ctl_addr <= sel_addr;
        ctl_wr_d <= sel_wdata;
      end
      if (start)    got_q <= 1'b0;
      else if (cap) got_q <= 1'b1;
      if (cap) rdata <= ctl_rd_d;
      if (cnt_clr)
        cnt_q <= '0;
      else if (state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE)
        cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_hyper_arb.sv
// tb_hyper_arb: directed bench for hyper_arb with a small behavioural
// controller model (busy for three cycles after a request, rd_rdy one cycle
// before busy falls) that can be swapped for hand-driven controller inputs.
module tb_hyper_arb;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 1023;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_l = 1'b1;
  always #5 clk = ~clk;

  logic          p0_req = 1'b0, p1_req = 1'b0, p0_we = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_done, p1_done, p0_err, p1_err;
  logic [DW-1:0] rdata;
  logic          ctl_rd_req, ctl_wr_req;
  logic [AW-1:0] ctl_addr;
  logic [DW-1:0] ctl_wr_d;
  logic [DW-1:0] ctl_rd_d;
  logic          ctl_rd_rdy, ctl_busy;
  logic [2:0]    dbg_state;

  // Controller inputs: model-driven or forced by hand.
  logic          model_en = 1'b1;
  logic          m_busy = 1'b0, m_rdy = 1'b0;
  logic [DW-1:0] m_rd_d = '0;
  logic          f_busy = 1'b0, f_rdy = 1'b0;
  logic [DW-1:0] f_rd_d = '0;
  assign ctl_busy   = model_en ? m_busy : f_busy;
  assign ctl_rd_rdy = model_en ? m_rdy  : f_rdy;
  assign ctl_rd_d   = model_en ? m_rd_d : f_rd_d;

  hyper_arb #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rst_l(rst_l),
    .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_done(p0_done), .p1_done(p1_done), .p0_err(p0_err), .p1_err(p1_err),
    .rdata(rdata), .ctl_rd_req(ctl_rd_req), .ctl_wr_req(ctl_wr_req),
    .ctl_addr(ctl_addr), .ctl_wr_d(ctl_wr_d), .ctl_rd_d(ctl_rd_d),
    .ctl_rd_rdy(ctl_rd_rdy), .ctl_busy(ctl_busy), .dbg_state(dbg_state)
  );

  // ---------------- controller + memory model ----------------
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            m_left = 0;
  logic          m_is_rd = 1'b0;
  logic [AW-1:0] m_addr = '0;

  always @(negedge clk) begin
    m_rdy = 1'b0;
    if (model_en && (ctl_wr_req || ctl_rd_req)) begin
      m_busy  = 1'b1;
      m_left  = 3;
      m_is_rd = ctl_rd_req;
      m_addr  = ctl_addr;
      if (ctl_wr_req) mem[ctl_addr] = ctl_wr_d;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 1 && m_is_rd) begin
        m_rdy  = 1'b1;
        m_rd_d = mem.exists(m_addr) ? mem[m_addr] : '0;
      end
      if (m_left == 0) m_busy = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] sb_exp;
  logic          prev_req = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=no event required=event within bound", name);
  endtask

  // Read data on every rvalid against the queued expectation; request pulses
  // must be exclusive, paired with a grant and never back to back.
  always @(negedge clk) begin
    if (p0_rvalid || p1_rvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rvalid_unexpected actual rdata=0x%0h required=no rvalid", rdata);
      end else begin
        sb_exp = exp_q.pop_front();
        if (rdata !== sb_exp) begin
          failures++;
          $display("FAIL rdata actual=0x%0h required=0x%0h", rdata, sb_exp);
        end
      end
      checks++;
      if (!(p0_rvalid ? p0_done : p1_done)) begin
        failures++;
        $display("FAIL rvalid_without_done actual done=0 required=1");
      end
    end
    if (ctl_rd_req || ctl_wr_req || p0_gnt || p1_gnt) begin
      checks++;
      if (prev_req || (ctl_rd_req && ctl_wr_req) || (p0_gnt && p1_gnt) ||
          ((ctl_rd_req || ctl_wr_req) != (p0_gnt || p1_gnt))) begin
        failures++;
        $display("FAIL req_pulse actual rd=%0b wr=%0b g0=%0b g1=%0b prev=%0b required=one exclusive pulse",
                 ctl_rd_req, ctl_wr_req, p0_gnt, p1_gnt, prev_req);
      end
    end
    prev_req = ctl_rd_req || ctl_wr_req;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int port, input logic req, input logic we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  task automatic wait_gnt(input int port, input int limit, output int n, output logic seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      @(negedge clk);
      n++;
      seen = (port == 1) ? p1_gnt : p0_gnt;
    end
  endtask

  task automatic wait_done(input int port, input int limit, output int n, output logic seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      @(negedge clk);
      n++;
      seen = (port == 1) ? p1_done : p0_done;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},    64'({p0_gnt, p1_gnt}), 64'd0);
    check({tag, "_rvalid"}, 64'({p0_rvalid, p1_rvalid}), 64'd0);
    check({tag, "_done"},   64'({p0_done, p1_done}), 64'd0);
    check({tag, "_err"},    64'({p0_err, p1_err}), 64'd0);
    check({tag, "_ctl_req"}, 64'({ctl_rd_req, ctl_wr_req}), 64'd0);
    check({tag, "_ctl_addr"}, 64'(ctl_addr), 64'd0);
    check({tag, "_ctl_wr_d"}, 64'(ctl_wr_d), 64'd0);
    check({tag, "_rdata"},  64'(rdata), 64'd0);
    check({tag, "_state"},  64'(dbg_state), 64'(ST_IDLE));
  endtask

  // One transaction against the model from an idle arbiter: grant one cycle
  // after the request is sampled, done four cycles after the grant cycle.
  task automatic run_txn(input int port, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                         input string tag);
    int   n;
    logic seen;
    @(negedge clk);
    drive_req(port, 1'b1, we, addr, wdata);
    if (!we) exp_q.push_back(exp_rdata);
    wait_gnt(port, 20, n, seen);
    if (!seen) begin
      fail_now({tag, "_gnt_timeout"});
      drive_req(port, 1'b0, we, addr, wdata);
      return;
    end
    check({tag, "_gnt_lat"}, 64'(n), 64'd1);
    check({tag, "_ctl_addr"}, 64'(ctl_addr), 64'(addr));
    if (we) check({tag, "_ctl_wr_d"}, 64'(ctl_wr_d), 64'(wdata));
    check({tag, "_wr_req"}, 64'(ctl_wr_req), 64'(we));
    check({tag, "_rd_req"}, 64'(ctl_rd_req), 64'(!we));
    drive_req(port, 1'b0, we, addr, wdata);
    wait_done(port, 20, n, seen);
    if (!seen) begin
      fail_now({tag, "_done_timeout"});
      return;
    end
    check({tag, "_done_lat"}, 64'(n), 64'd4);
    check({tag, "_err"}, 64'(port == 1 ? p1_err : p0_err), 64'd0);
    check({tag, "_rvalid"}, 64'(port == 1 ? p1_rvalid : p0_rvalid), 64'(!we));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  localparam int NV = 7;
  vec_t vec[NV];

  initial begin
    #1000000;
    $display("FAIL watchdog actual=time limit reached required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic seen;

    vec[0] = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    vec[1] = '{1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    vec[2] = '{1, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 32'h0};
    vec[3] = '{0, 1'b0, 32'h0000_0030, 32'h0,         32'h0};
    vec[4] = '{0, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 32'h0};
    vec[5] = '{0, 1'b0, 32'h0000_0020, 32'h0,         32'h0BAD_F00D};
    vec[6] = '{1, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'hA5A5_A5A5};

    // Reset: asynchronous assertion before any clock edge.
    #2 rst_l = 1'b0;
    #1 check_zero("rst_async");
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    check_zero("rst_release");

    // Table of single transactions, alternating ports and directions.
    for (int i = 0; i < NV; i++)
      run_txn(vec[i].port, vec[i].we, vec[i].addr, vec[i].wdata, vec[i].exp_rdata,
              $sformatf("vec%0d", i));

    // Spurious rd_rdy while idle: no capture, no rvalid.
    @(negedge clk);
    model_en = 1'b0;
    f_rd_d = 32'h0000_1234;
    f_rdy  = 1'b1;
    @(negedge clk);
    f_rdy  = 1'b0;
    @(negedge clk);
    check("spur_rdata", 64'(rdata), 64'hA5A5_A5A5);
    check("spur_state", 64'(dbg_state), 64'(ST_IDLE));
    model_en = 1'b1;

    // Contention: both ports request continuously; last served was port 1.
    @(negedge clk);
    drive_req(0, 1'b1, 1'b1, 32'h0000_0100, 32'h1111_0000);
    drive_req(1, 1'b1, 1'b1, 32'h0000_0104, 32'h2222_0000);
    for (int i = 0; i < 6; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(p0_gnt || p1_gnt) && n < 30);
      if (!(p0_gnt || p1_gnt)) begin
        fail_now($sformatf("ctn_grant%0d_timeout", i));
        break;
      end
      check($sformatf("ctn_grant%0d", i), 64'({p0_gnt, p1_gnt}), (i % 2 == 1) ? 64'd1 : 64'd2);
      check($sformatf("ctn_spacing%0d", i), 64'(n), (i == 0) ? 64'd1 : 64'd6);
    end
    drive_req(0, 1'b0, 1'b0, '0, '0);
    drive_req(1, 1'b0, 1'b0, '0, '0);
    wait_done(1, 20, n, seen);
    if (!seen) fail_now("ctn_last_done");

    // Timeout: controller never raises busy during a port 0 read.
    model_en = 1'b0;
    f_busy   = 1'b0;
    @(negedge clk);
    drive_req(0, 1'b1, 1'b0, 32'h0000_0050, '0);
    wait_gnt(0, 20, n, seen);
    drive_req(0, 1'b0, 1'b0, '0, '0);
    if (!seen) begin
      fail_now("tmo_gnt");
    end else begin
      wait_done(0, TMO + 20, n, seen);
      if (!seen) begin
        fail_now("tmo_done");
      end else begin
        check("tmo_cycles", 64'(n), 64'(TMO + 1));
        check("tmo_err", 64'(p0_err), 64'd1);
        check("tmo_rvalid", 64'(p0_rvalid), 64'd0);
        check("tmo_rdata", 64'(rdata), 64'hA5A5_A5A5);
        @(negedge clk);
        check("tmo_pulse_end", 64'({p0_done, p0_err}), 64'd0);
        check("tmo_idle", 64'(dbg_state), 64'(ST_IDLE));
      end
    end
    model_en = 1'b1;
    run_txn(1, 1'b0, 32'h0000_0010, '0, 32'hDEAD_BEEF, "post_tmo");

    // rd_rdy arriving in the same cycle busy falls completes the read.
    model_en = 1'b0;
    @(negedge clk);
    drive_req(0, 1'b1, 1'b0, 32'h0000_0040, '0);
    exp_q.push_back(32'h5A5A_0001);
    wait_gnt(0, 20, n, seen);
    drive_req(0, 1'b0, 1'b0, '0, '0);
    if (!seen) begin
      fail_now("late_rdy_gnt");
      void'(exp_q.pop_back());
    end else begin
      f_busy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("late_rdy_state", 64'(dbg_state), 64'(ST_WAIT_DONE));
      f_busy = 1'b0;
      f_rdy  = 1'b1;
      f_rd_d = 32'h5A5A_0001;
      @(negedge clk);
      f_rdy  = 1'b0;
      check("late_rdy_done", 64'({p0_done, p0_rvalid, p0_err}), 64'd6);
      check("late_rdy_rdata", 64'(rdata), 64'h5A5A_0001);
    end
    @(negedge clk);
    model_en = 1'b1;

    // Reset in the middle of a read, then the first tie goes to port 0.
    @(negedge clk);
    drive_req(1, 1'b1, 1'b0, 32'h0000_0010, '0);
    exp_q.push_back(32'hDEAD_BEEF);
    wait_gnt(1, 20, n, seen);
    drive_req(1, 1'b0, 1'b0, '0, '0);
    if (!seen) fail_now("rst_mid_gnt");
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_state", 64'(dbg_state), 64'(ST_WAIT_DONE));
    rst_l = 1'b0;
    #1 check_zero("rst_mid");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    repeat (4) @(negedge clk);
    drive_req(0, 1'b1, 1'b1, 32'h0000_0200, 32'h3333_0000);
    drive_req(1, 1'b1, 1'b1, 32'h0000_0204, 32'h4444_0000);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(p0_gnt || p1_gnt) && n < 20);
    drive_req(0, 1'b0, 1'b0, '0, '0);
    drive_req(1, 1'b0, 1'b0, '0, '0);
    if (!(p0_gnt || p1_gnt)) begin
      fail_now("post_rst_tie");
    end else begin
      check("post_rst_tie", 64'({p0_gnt, p1_gnt}), 64'd2);
      wait_done(0, 20, n, seen);
      if (!seen) fail_now("post_rst_done");
    end

    repeat (3) @(negedge clk);
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hyper_arb.md
# hyper_arb

Two-port round-robin arbiter that shares one `hyper_xfce` HyperRAM controller between two independent requesters, for example a CPU-side port and a DMA-side port. It accepts single-dword read and write requests, issues them one at a time as `rd_req`/`wr_req` pulses, and tracks controller `busy`/`rd_rdy` to completion. Read data is returned to the owning port, and a stalled transaction is aborted by timeout. It sits between the requesters and the controller's user-side ports; the controller's DRAM-side pins are untouched.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width; matches controller `wr_d`/`rd_d`.
- `TMO`, 1023, timeout in clk cycles per phase; 10-bit counter.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_l`  in  1  asynchronous, active-low reset.
- `p0_req`, `p1_req`  in  1  request valid; held until `pN_gnt`.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read; stable while req.
- `p0_addr`, `p1_addr`  in  AW  dword address.
- `p0_wdata`, `p1_wdata`  in  DW  write data.
- `p0_gnt`, `p1_gnt`  out  1  one-cycle pulse; request accepted.
- `p0_rvalid`, `p1_rvalid`  out  1  one-cycle pulse; `rdata` valid.
- `p0_done`, `p1_done`  out  1  one-cycle pulse; transaction complete, read or write.
- `p0_err`, `p1_err`  out  1  one-cycle pulse with `done` when the transaction was aborted by timeout.
- `rdata`  out  DW  shared read-data register.
- `ctl_rd_req`, `ctl_wr_req`  out  1  to controller `rd_req`/`wr_req`.
- `ctl_addr`  out  AW  to controller `addr`.
- `ctl_wr_d`  out  DW  to controller `wr_d`.
- `ctl_rd_d`  in  DW  from controller `rd_d`.
- `ctl_rd_rdy`  in  1  from controller `rd_rdy`.
- `ctl_busy`  in  1  from controller `busy`.

## Operation
- **States:**
  - IDLE: waits for a request.
  - ISSUE: request pulse driven to the controller.
  - WAIT_BUSY: waits for the controller to take the request.
  - WAIT_DONE: waits for the controller to finish.
  - RESP: completion reported to the owner.
- **IDLE:** when `ctl_busy`=0 and any request is high, pick the owner.
  - If only one port requests, that port wins.
  - If both request, the port not served last wins.
  - `last` resets to 1, so port 0 wins the first tie.
  - On the next edge: latch owner, `we`, `addr`, `wdata` into `ctl_addr`/`ctl_wr_d`; pulse `pN_gnt`; assert `ctl_wr_req` or `ctl_rd_req`; go to ISSUE; update `last`.
- **ISSUE:** `ctl_*_req` is high for exactly this one cycle. Next state is WAIT_BUSY, and the timeout counter clears.
- **WAIT_BUSY:**
  - `ctl_busy`=1 → WAIT_DONE, counter clears.
  - Counter reaches TMO → RESP with err.
- **WAIT_DONE:**
  - Read: `ctl_rd_rdy`=1 captures `ctl_rd_d` into `rdata` and sets a `got` flag. Leave when `ctl_busy`=0 and `got`=1.
  - Write: leave when `ctl_busy`=0.
  - Counter reaches TMO → RESP with err.
  - `ctl_rd_rdy` with `ctl_busy` already low in the same cycle counts as completion.
- **RESP:** one cycle, then IDLE.
  - Pulse `pN_done`.
  - On a read, also pulse `pN_rvalid`, unless err.
  - On timeout, pulse `pN_err`; `rdata` is left unchanged.
- **Addresses and data:** `ctl_addr`/`ctl_wr_d` hold their value from grant until the next grant. The arbiter does no address arithmetic; addresses pass through unchanged.
- **Unexpected controller signals:** `ctl_rd_rdy` outside WAIT_DONE is ignored. A new request arriving during any non-IDLE state waits.
- **Reset:** asserting `rst_l`=0 at any time forces IDLE immediately and abandons any in-flight transaction without notifying the controller.
  - Reset value 0: all pulse outputs, `ctl_rd_req`, `ctl_wr_req`, `ctl_addr`, `ctl_wr_d`, `rdata`, counter, `got`.
  - Reset value 1: `last`.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Grant latency: request sampled in IDLE at edge N gives `gnt` and `ctl_*_req` high during cycle N+1.
- Minimum transaction is 4 cycles plus controller busy time: ISSUE, ≥1 WAIT_BUSY, ≥1 WAIT_DONE, RESP.
- `pN_done`/`rvalid` assert one cycle after completion is detected.
- At most one `ctl_*_req` pulse per transaction, never two in consecutive cycles.
- Back-to-back requests from one port: the next grant is no earlier than 1 cycle after RESP.
- Under continuous requests from both ports, grants alternate strictly 0,1,0,1.

## Test plan
- **Single write:** p0 writes addr 0x10, data 0xDEADBEEF. Expect `p0_gnt` at N+1; `ctl_wr_req` 1 cycle with `ctl_addr`=0x10 and `ctl_wr_d`=0xDEADBEEF; `p0_done` after busy falls; no `rvalid`.
- **Read-back:** p1 reads 0x10 against the controller plus HyperRAM model. Expect `p1_rvalid` with `rdata`=0xDEADBEEF and `p1_done` in the same cycle.
- **Contention:** p0 and p1 request together, continuously, for 6 transactions. Expect grants 0,1,0,1,0,1 and no overlapping `ctl_*_req`.
- **Timeout:** `ctl_busy` tied 0. Expect `p0_done` and `p0_err` exactly TMO+1 cycles after ISSUE, then the arbiter returns to IDLE and serves the next request.
- **Spurious `rd_rdy`:** pulse `ctl_rd_rdy` in IDLE with `ctl_rd_d`=0x1234. Expect `rdata` unchanged and no `rvalid`.
- **Reset mid-read:** `rst_l` low in WAIT_DONE. Expect all outputs 0 immediately; after release, p0 wins the first tie.
